// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and architectural constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding memory read, holds the fetched word
// toward decode until accepted, with redirect (flush) and misalignment trapping.
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT,
    parameter bit          TRAP_ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_err,
    output logic [31:0] fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         inst_valid_q, inst_valid_d;
    logic         inst_err_q, inst_err_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         drop_q, drop_d;

    logic misaligned;
    logic accept;

    assign misaligned = TRAP_ALIGN_CHECK && is_misaligned(fetch_pc_q);
    assign accept     = inst_valid_q && inst_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect wins over every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    state_d = (!misaligned && imem_gnt) ? S_WAIT : S_REQ;
                end else if (misaligned) begin
                    state_d = S_HOLD;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = (redirect || drop_q) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || accept) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        imem_req  = (state_q == S_REQ) && !misaligned;
        imem_addr = fetch_pc_q;
    end

    // Datapath next-state: fetch address, delivered instruction, drop flag, counter
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        inst_err_d   = inst_err_q;
        fetch_cnt_d  = fetch_cnt_q;
        drop_d       = drop_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (!misaligned && imem_gnt) begin
                        drop_d = 1'b1;
                    end
                end else if (misaligned) begin
                    inst_d       = NOP_INST;
                    pc_d         = fetch_pc_q;
                    inst_err_d   = 1'b1;
                    inst_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                // A redirect coincident with rvalid discards that response outright
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    drop_d     = !imem_rvalid;
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        inst_d       = imem_rdata;
                        pc_d         = fetch_pc_q;
                        inst_err_d   = 1'b0;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_d   = redirect_pc;
                    inst_valid_d = 1'b0;
                    inst_err_d   = 1'b0;
                end else if (accept) begin
                    fetch_pc_d   = npc;
                    inst_valid_d = 1'b0;
                    inst_err_d   = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_err_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            inst_err_q   <= inst_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_err   = inst_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: per-cycle vector table plus directed multi-cycle sequences.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_err;
    logic [31:0] fetch_cnt;

    logic        mem_rvalid;
    logic        inj_rvalid;
    logic        npc_ovr_en;
    logic [31:0] npc_ovr;
    int          gnt_delay;
    int          rvalid_delay;
    int          tests = 0;
    int          fails = 0;

    assign imem_rvalid = mem_rvalid | inj_rvalid;
    assign npc         = npc_ovr_en ? npc_ovr : pc + 32'd4;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC        (32'h0000_0000),
        .TRAP_ALIGN_CHECK(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .inst_err   (inst_err),
        .fetch_cnt  (fetch_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory model: grant after gnt_delay cycles of request, data rvalid_delay cycles after grant
    initial begin : memory
        logic        pending;
        logic [31:0] p_addr;
        int          wait_cnt;
        int          req_age;
        pending = 1'b0; p_addr = '0; wait_cnt = 0; req_age = 0;
        mem_rvalid = 1'b0; imem_gnt = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            imem_gnt   = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
                req_age = 0;
            end else begin
                if (pending) begin
                    if (wait_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        imem_rdata = mem_word(p_addr);
                        pending    = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (imem_req && !pending) begin
                    if (req_age >= gnt_delay) begin
                        imem_gnt = 1'b1;
                        pending  = 1'b1;
                        p_addr   = imem_addr;
                        wait_cnt = rvalid_delay - 1;
                        req_age  = 0;
                    end else begin
                        req_age++;
                    end
                end else begin
                    req_age = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the caller at the drive point of the first post-reset cycle (S_IDLE)
    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        npc_ovr_en = 1'b0; inj_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [19];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r;
        int req_cycles, addr_bad, rv_row, v_row;
        bit found, saw_valid;

        // Zero-wait stream, then 5-cycle decode stall on the fourth instruction
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000_0000, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000_0000, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000_0000, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'hC0DE_0000, 32'd0};
        tbl[4]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'hC0DE_0000, 32'd1};
        tbl[5]  = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 32'hC0DE_0000, 32'd1};
        tbl[6]  = '{1'b1, 1'b0, 32'h04, 1'b1, 32'h04, 32'hC0DE_0004, 32'd1};
        tbl[7]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h04, 32'hC0DE_0004, 32'd2};
        tbl[8]  = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h04, 32'hC0DE_0004, 32'd2};
        tbl[9]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h08, 32'hC0DE_0008, 32'd2};
        tbl[10] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h08, 32'hC0DE_0008, 32'd3};
        tbl[11] = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h08, 32'hC0DE_0008, 32'd3};
        for (int i = 12; i <= 16; i++)
            tbl[i] = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h0C, 32'hC0DE_000C, 32'd3};
        tbl[17] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h0C, 32'hC0DE_000C, 32'd3};
        tbl[18] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h0C, 32'hC0DE_000C, 32'd4};

        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        npc_ovr_en = 1'b0; npc_ovr = '0; inj_rvalid = 1'b0;
        gnt_delay = 0; rvalid_delay = 1;

        #12;
        check("rst.imem_req", {31'd0, imem_req}, 32'd0);
        check("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst.inst_err", {31'd0, inst_err}, 32'd0);
        check("rst.pc", pc, 32'h0);
        check("rst.inst", inst, 32'h0);
        check("rst.fetch_cnt", fetch_cnt, 32'd0);

        // Vector table from reset release
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            inst_ready = tbl[i].rdy;
            sample();
            check($sformatf("row%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            check($sformatf("row%0d.addr", i), imem_addr, tbl[i].addr);
            check($sformatf("row%0d.valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].valid});
            check($sformatf("row%0d.pc", i), pc, tbl[i].pc);
            check($sformatf("row%0d.inst", i), inst, tbl[i].inst);
            check($sformatf("row%0d.cnt", i), fetch_cnt, tbl[i].cnt);
            tick();
        end

        // Slow memory: grant after 3 request cycles, data 2 cycles after grant
        gnt_delay = 3; rvalid_delay = 2;
        do_reset();
        inst_ready = 1'b1;
        req_cycles = 0; addr_bad = 0; rv_row = -1; v_row = -1;
        for (int k = 0; k < 16; k++) begin
            sample();
            if (imem_req) begin
                req_cycles++;
                if (imem_addr !== 32'h0) addr_bad++;
            end
            if (imem_rvalid && rv_row < 0) rv_row = k;
            if (inst_valid) begin
                v_row = k;
                break;
            end
            tick();
        end
        check("slow.req_cycles", req_cycles, 32'd4);
        check("slow.addr_unstable", addr_bad, 32'd0);
        check("slow.rvalid_row", rv_row, 32'd6);
        check("slow.valid_row", v_row, 32'd7);
        check("slow.inst", inst, 32'hC0DE_0000);

        // Redirect while waiting: pending response dropped, refetch at 0x100
        gnt_delay = 0; rvalid_delay = 3;
        do_reset();
        inst_ready = 1'b1;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        found = 1'b0; saw_valid = 1'b0; r = 3;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (inst_valid) saw_valid = 1'b1;
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            tick();
            r++;
        end
        check("redir.req_seen", {31'd0, found}, 32'd1);
        check("redir.req_row", r, 32'd5);
        check("redir.addr", imem_addr, 32'h100);
        check("redir.no_stale_valid", {31'd0, saw_valid}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            sample();
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("redir.valid_seen", {31'd0, found}, 32'd1);
        check("redir.pc", pc, 32'h100);
        check("redir.inst", inst, 32'hC0DE_0100);
        check("redir.cnt", fetch_cnt, 32'd0);

        // Misaligned npc, redirect in hold, counter wrap, reset in S_WAIT
        gnt_delay = 0; rvalid_delay = 1;
        do_reset();
        inst_ready = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h102;
        tick(); tick(); tick();
        sample();
        check("mis.first_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        inst_ready = 1'b0; npc_ovr_en = 1'b0;
        sample();
        check("mis.no_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
        sample();
        check("mis.valid", {31'd0, inst_valid}, 32'd1);
        check("mis.inst", inst, 32'h0000_0013);
        check("mis.err", {31'd0, inst_err}, 32'd1);
        check("mis.pc", pc, 32'h102);
        check("mis.cnt", fetch_cnt, 32'd1);
        tick();
        redirect = 1'b0; inst_ready = 1'b0;
        sample();
        check("hold_redir.valid", {31'd0, inst_valid}, 32'd0);
        check("hold_redir.err", {31'd0, inst_err}, 32'd0);
        check("hold_redir.cnt", fetch_cnt, 32'd1);
        check("hold_redir.req", {31'd0, imem_req}, 32'd1);
        check("hold_redir.addr", imem_addr, 32'h200);
        tick(); tick();
        sample();
        check("wrap.valid", {31'd0, inst_valid}, 32'd1);
        check("wrap.pc", pc, 32'h200);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_cnt_q;
        inst_ready = 1'b1;
        sample();
        check("wrap.preload", fetch_cnt, 32'hFFFF_FFFF);
        tick();
        inst_ready = 1'b0;
        sample();
        check("wrap.cnt", fetch_cnt, 32'd0);
        check("wrap.addr", imem_addr, 32'h204);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst.req", {31'd0, imem_req}, 32'd0);
        check("async_rst.valid", {31'd0, inst_valid}, 32'd0);
        check("async_rst.err", {31'd0, inst_err}, 32'd0);
        check("async_rst.pc", pc, 32'h0);
        check("async_rst.inst", inst, 32'h0);
        check("async_rst.addr", imem_addr, 32'h0);

        // Stray rvalid in S_IDLE/S_REQ after reset release must be ignored
        gnt_delay = 2; inj_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("stray%0d.valid", k), {31'd0, inst_valid}, 32'd0);
            if (k > 0) check($sformatf("stray%0d.req", k), {31'd0, imem_req}, 32'd1);
            tick();
        end
        inj_rvalid = 1'b0;
        inst_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("stray.valid_seen", {31'd0, found}, 32'd1);
        check("stray.pc", pc, 32'h0);
        check("stray.inst", inst, 32'hC0DE_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
